// File: rtl/xm_skid_stage.sv
// xm_skid_stage: execute-to-memory pipeline register built as a 2-entry skid
// buffer. The head (main) entry drives out_*, and a skid entry absorbs one
// word while the memory stage stalls. in_ready is a flop, so there is no
// combinational path from out_ready back into the ALU.
//
// At capture, an overflowed result is rewritten to the rstatus form. The
// result becomes the exception code, rd becomes RSTATUS_REG and we is forced
// to 1. Any write to r0 has its write enable dropped.
//
// Optional feature: define XM_BYPASS_EN to add the byp_valid, byp_rd and
// byp_result forwarding outputs, which are taken from the main entry.
module xm_skid_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int RSTATUS_REG = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_we,
  input  logic              in_ovf,
  input  logic [1:0]        in_exc_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_we,
  output logic [1:0]        occupancy
`ifdef XM_BYPASS_EN
  ,
  output logic              byp_valid,
  output logic [REG_W-1:0]  byp_rd,
  output logic [DATA_W-1:0] byp_result
`endif
);

  // Entry state
  logic              main_valid_reg, main_valid_next;
  logic [DATA_W-1:0] main_result_reg, main_result_next;
  logic [REG_W-1:0]  main_rd_reg, main_rd_next;
  logic              main_we_reg, main_we_next;

  logic              skid_valid_reg, skid_valid_next;
  logic [DATA_W-1:0] skid_result_reg, skid_result_next;
  logic [REG_W-1:0]  skid_rd_reg, skid_rd_next;
  logic              skid_we_reg, skid_we_next;

  logic              in_ready_reg, in_ready_next;
  logic [1:0]        occupancy_reg, occupancy_next;

  // Captured (rewritten) form of the incoming word
  logic [DATA_W-1:0] cap_result;
  logic [REG_W-1:0]  cap_rd;
  logic              cap_we;

  logic accept;
  logic pop;

  assign accept = in_valid & in_ready_reg;
  assign pop    = main_valid_reg & out_ready;

  // Apply the overflow rewrite first, then drop the write enable for r0
  always_comb begin
    cap_result = in_result;
    cap_rd     = in_rd;
    cap_we     = in_we;
    if (in_ovf) begin
      cap_result = DATA_W'(in_exc_code);
      cap_rd     = REG_W'(RSTATUS_REG);
      cap_we     = 1'b1;
    end
    if (cap_rd == '0) begin
      cap_we = 1'b0;
    end
  end

  // Next-state for both entries. A flush overrides everything, including a
  // same-edge accept.
  always_comb begin
    main_valid_next  = main_valid_reg;
    main_result_next = main_result_reg;
    main_rd_next     = main_rd_reg;
    main_we_next     = main_we_reg;
    skid_valid_next  = skid_valid_reg;
    skid_result_next = skid_result_reg;
    skid_rd_next     = skid_rd_reg;
    skid_we_next     = skid_we_reg;

    if (flush) begin
      // Data fields are cleared too, so the forwarding outputs read zero
      main_valid_next  = 1'b0;
      main_result_next = '0;
      main_rd_next     = '0;
      main_we_next     = 1'b0;
      skid_valid_next  = 1'b0;
      skid_result_next = '0;
      skid_rd_next     = '0;
      skid_we_next     = 1'b0;
    end else if (!main_valid_reg) begin
      // Empty: the skid entry is never valid without a valid main entry
      if (accept) begin
        main_valid_next  = 1'b1;
        main_result_next = cap_result;
        main_rd_next     = cap_rd;
        main_we_next     = cap_we;
      end
    end else if (!skid_valid_reg) begin
      // Main only
      if (accept && pop) begin
        main_result_next = cap_result;
        main_rd_next     = cap_rd;
        main_we_next     = cap_we;
      end else if (accept) begin
        skid_valid_next  = 1'b1;
        skid_result_next = cap_result;
        skid_rd_next     = cap_rd;
        skid_we_next     = cap_we;
      end else if (pop) begin
        main_valid_next  = 1'b0;
      end
    end else begin
      // Full: in_ready is low, so only a pop can change anything
      if (pop) begin
        main_result_next = skid_result_reg;
        main_rd_next     = skid_rd_reg;
        main_we_next     = skid_we_reg;
        skid_valid_next  = 1'b0;
      end
    end

    in_ready_next  = ~skid_valid_next;
    occupancy_next = {1'b0, main_valid_next} + {1'b0, skid_valid_next};
  end

  // State registers, cleared asynchronously while reset is low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid_reg  <= 1'b0;
      main_result_reg <= '0;
      main_rd_reg     <= '0;
      main_we_reg     <= 1'b0;
      skid_valid_reg  <= 1'b0;
      skid_result_reg <= '0;
      skid_rd_reg     <= '0;
      skid_we_reg     <= 1'b0;
      in_ready_reg    <= 1'b0;
      occupancy_reg   <= 2'd0;
    end else begin
      main_valid_reg  <= main_valid_next;
      main_result_reg <= main_result_next;
      main_rd_reg     <= main_rd_next;
      main_we_reg     <= main_we_next;
      skid_valid_reg  <= skid_valid_next;
      skid_result_reg <= skid_result_next;
      skid_rd_reg     <= skid_rd_next;
      skid_we_reg     <= skid_we_next;
      in_ready_reg    <= in_ready_next;
      occupancy_reg   <= occupancy_next;
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = main_valid_reg;
  assign out_result = main_result_reg;
  assign out_rd     = main_rd_reg;
  assign out_we     = main_we_reg;
  assign occupancy  = occupancy_reg;

`ifdef XM_BYPASS_EN
  assign byp_valid  = main_valid_reg & main_we_reg;
  assign byp_rd     = main_rd_reg;
  assign byp_result = main_result_reg;
`endif

endmodule

// File: doc/xm_skid_stage.md
Name: xm_skid_stage

Overview:
- Execute→memory pipeline stage directly downstream of the ALU (adder, logic unit, barrel shifters).
- Registers each ALU result with its destination register and overflow status into a 2-entry skid buffer with valid/ready handshakes on both sides.
- The memory stage can stall without a combinational ready path back into the ALU.
- Overflow results are rewritten to the rstatus convention before they leave the stage.

Parameters:
- DATA_W, 32, result width.
- REG_W, 5, register-index width.
- RSTATUS_REG, 30, register index written on overflow.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when 0.
- flush  in  1  synchronous kill of both entries (branch/jump redirect).
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept; registered, not a function of out_ready.
- in_result  in  DATA_W  ALU/shifter result.
- in_rd  in  REG_W  destination register.
- in_we  in  1  instruction writes a register.
- in_ovf  in  1  ALU signalled overflow.
- in_exc_code  in  2  overflow code: 1=add, 2=addi, 3=sub.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts head.
- out_result  out  DATA_W  head result.
- out_rd  out  REG_W  head destination.
- out_we  out  1  head write enable.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage:
  - Main entry (head, drives out_*) and skid entry.
  - Each entry holds result, rd, we and a valid bit.
- Reset (reset=0, asynchronous):
  - Both valid bits clear; all out_* fields 0; occupancy=0.
  - in_ready=1 from the first edge after reset deasserts.
- Acceptance:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Latency: a word accepted on edge N appears on out_* after edge N (one cycle) when the stage was empty.
- Per-edge transitions (no flush):
  - Empty, accept → main.
  - Main only, accept & pop → main replaced by new word.
  - Main only, accept & !pop → new word to skid; in_ready falls.
  - Main only, pop & !accept → empty.
  - Full, pop → skid moves to main; in_ready rises.
  - Full, !pop → hold. in_ready=0, so accept cannot occur.
- in_ready is a flop equal to !skid_valid. It never depends combinationally on out_ready or in_valid.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Overflow rewrite at capture when in_ovf=1:
  - stored result = zero-extended in_exc_code.
  - stored rd = RSTATUS_REG; stored we = 1.
  - in_exc_code=0 with in_ovf=1 stores result 0 (legal, no special case).
- rd=0 rule: stored we is forced to 0 when the final rd is 0.
- flush=1 at an edge:
  - Both entries are invalidated; an accept on that same edge is discarded.
  - in_ready=1 on the next cycle; occupancy=0.
  - The memory stage still sees the old head during the flush cycle and may pop it.
- Output hold: out_* hold stable while out_valid & !out_ready.
- occupancy: registered count of valid entries, consistent with the valid bits after every edge.

Optional Feature:
- Macro XM_BYPASS_EN.
- When defined, three extra outputs drive the ALU operand-forwarding mux:
  - byp_valid (1) = main valid & main we.
  - byp_rd (REG_W) = main rd.
  - byp_result (DATA_W) = main result.
  - All are combinational from the main entry; they are 0 during reset and after flush.
- When undefined, these ports do not exist and no logic is generated.

Test Plan:
- Reset while full: load 2 words, pull reset=0 mid-cycle → out_valid=0, occupancy=0 immediately, without waiting for a clock edge; in_ready=1 after release.
- Streaming: out_ready=1, in_valid=1 with results 0x00000001..0x00000008 on back-to-back cycles → outputs in order, each one cycle after input; in_ready stays 1; occupancy stays 1.
- Backpressure: out_ready=0, send 0xAAAA0000 then 0xBBBB0000 → in_ready=0 after the 2nd; occupancy=2. Raise out_ready → 0xAAAA0000 then 0xBBBB0000 pop; in_ready=1 after the first pop.
- Overflow: in_ovf=1, in_exc_code=3, in_rd=7, in_result=0x80000000 → out_result=0x00000003, out_rd=30, out_we=1.
- rd zero: in_rd=0, in_we=1, result 0x12345678 → out_we=0, out_result=0x12345678.
- Flush with accept: stage full, flush=1 and in_valid=1 (data 0xDEADBEEF) on the same edge → next cycle out_valid=0, occupancy=0; 0xDEADBEEF never appears at the output.
